// File: rtl/render_pkg.sv
// Shared types and constants for the sprite renderer: screen geometry, colours,
// FSM state encoding, square descriptor and the square-sequencing helper.
package render_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_PLAYER = 3'b010;
    localparam logic [2:0] COL_ENEMY  = 3'b100;
    localparam logic [2:0] COL_BG     = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        ERASE_P,
        DRAW_P,
        ERASE_E,
        DRAW_E,
        FINISH,
        CLEAR
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] size;
    } coord_t;

    // Next square state after s, skipping squares that have nothing to scan.
    function automatic state_t next_square(state_t s, logic v, logic [2:0] old_es,
                                           logic [2:0] new_es);
        state_t n;
        n = FINISH;
        case (s)
            IDLE, FINISH: n = v ? ERASE_P : DRAW_P;
            ERASE_P:      n = DRAW_P;
            DRAW_P:       n = (v && old_es != 3'd0) ? ERASE_E :
                              (new_es != 3'd0) ? DRAW_E : FINISH;
            ERASE_E:      n = (new_es != 3'd0) ? DRAW_E : FINISH;
            default:      n = FINISH;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/square_scanner.sv
// Row-major walker over one square (x fastest), one pixel per cycle while go is high.
// Offsets wrap to zero after the last pixel so the next square starts at its origin.
module square_scanner
    import render_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  coord_t     org,
    output logic [7:0] px,
    output logic [6:0] py,
    output logic       in_bounds,
    output logic       last
);
    logic [2:0] ox_q, oy_q;
    logic [8:0] sx;
    logic [7:0] sy;
    logic       row_end;

    // Widened sums: an origin near 255/127 must not wrap back onto the screen.
    assign sx        = {1'b0, org.x} + {6'd0, ox_q};
    assign sy        = {1'b0, org.y} + {5'd0, oy_q};
    assign px        = sx[7:0];
    assign py        = sy[6:0];
    assign in_bounds = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));
    assign row_end   = (ox_q == org.size - 3'd1);
    assign last      = row_end && (oy_q == org.size - 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            ox_q <= 3'd0;
            oy_q <= 3'd0;
        end else if (go) begin
            if (last) begin
                ox_q <= 3'd0;
                oy_q <= 3'd0;
            end else if (row_end) begin
                ox_q <= 3'd0;
                oy_q <= oy_q + 3'd1;
            end else begin
                ox_q <= ox_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_renderer.sv
// Erases and redraws the player and enemy squares as VGA pixel writes, one per clock.
// Define SPRITE_RENDERER_RESET_CLEAR_EN to blank the whole screen after reset.
module sprite_renderer
    import render_pkg::*;
#(
    parameter int         PLAYER_SIZE   = 4,
    parameter logic [2:0] PLAYER_COLOUR = COL_PLAYER,
    parameter logic [2:0] ENEMY_COLOUR  = COL_ENEMY,
    parameter logic [2:0] BG_COLOUR     = COL_BG
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] playerX,
    input  logic [6:0] playerY,
    input  logic [7:0] enemyX,
    input  logic [6:0] enemyY,
    input  logic [2:0] enemy_size,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] PSZ = 3'(PLAYER_SIZE);
`ifdef SPRITE_RENDERER_RESET_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t     state_q, scan_next;
    coord_t     new_p_q, new_e_q, old_p_q, old_e_q, org, smp_p, smp_e;
    logic       old_valid_q, pending_q;
    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] colour_q, scan_col;
    logic       plot_q, busy_q, done_q;
    logic       scan_go, scan_in, scan_last;
    logic [7:0] scan_x;
    logic [6:0] scan_y;
`ifdef SPRITE_RENDERER_RESET_CLEAR_EN
    logic [7:0] clr_x_q;
    logic [6:0] clr_y_q;
`endif

    assign smp_p = {playerX, playerY, PSZ};
    assign smp_e = {enemyX, enemyY, enemy_size};

    always_comb begin
        org      = new_p_q;
        scan_col = BG_COLOUR;
        scan_go  = 1'b1;
        case (state_q)
            ERASE_P: org = old_p_q;
            DRAW_P:  scan_col = PLAYER_COLOUR;
            ERASE_E: org = old_e_q;
            DRAW_E: begin
                org      = new_e_q;
                scan_col = ENEMY_COLOUR;
            end
            default: scan_go = 1'b0;
        endcase
    end

    assign scan_next = next_square(state_q, old_valid_q, old_e_q.size, new_e_q.size);

    square_scanner u_scan (
        .clk       (clk),
        .reset     (reset),
        .go        (scan_go),
        .org       (org),
        .px        (scan_x),
        .py        (scan_y),
        .in_bounds (scan_in),
        .last      (scan_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            new_p_q     <= '0;
            new_e_q     <= '0;
            old_p_q     <= '0;
            old_e_q     <= '0;
            old_valid_q <= 1'b0;
            pending_q   <= 1'b0;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            colour_q    <= BG_COLOUR;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SPRITE_RENDERER_RESET_CLEAR_EN
            clr_x_q     <= 8'd0;
            clr_y_q     <= 7'd0;
`endif
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            if (start && state_q != IDLE) pending_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start || pending_q) begin
                        new_p_q   <= smp_p;
                        new_e_q   <= smp_e;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= scan_next;
                    end
                end
                ERASE_P, DRAW_P, ERASE_E, DRAW_E: begin
                    x_q      <= scan_x;
                    y_q      <= scan_y;
                    colour_q <= scan_col;
                    plot_q   <= scan_in;
                    if (scan_last) begin
                        state_q <= scan_next;
                        // done lines up with the last pixel leaving the output register
                        if (scan_next == FINISH) done_q <= 1'b1;
                    end
                end
                FINISH: begin
                    old_p_q     <= new_p_q;
                    old_e_q     <= new_e_q;
                    old_valid_q <= 1'b1;
                    if (pending_q || start) begin
                        new_p_q   <= smp_p;
                        new_e_q   <= smp_e;
                        pending_q <= 1'b0;
                        state_q   <= ERASE_P;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
`ifdef SPRITE_RENDERER_RESET_CLEAR_EN
                CLEAR: begin
                    x_q      <= clr_x_q;
                    y_q      <= clr_y_q;
                    colour_q <= BG_COLOUR;
                    plot_q   <= 1'b1;
                    busy_q   <= 1'b1;
                    if (clr_x_q == 8'(SCREEN_W - 1)) begin
                        clr_x_q <= 8'd0;
                        if (clr_y_q == 7'(SCREEN_H - 1)) begin
                            clr_y_q <= 7'd0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            clr_y_q <= clr_y_q + 7'd1;
                        end
                    end else begin
                        clr_x_q <= clr_x_q + 8'd1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench: expected pixels are queued at stimulus time, a monitor pops on each plot.
module tb_sprite_renderer;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] playerX, enemyX;
    logic [6:0] playerY, enemyY;
    logic [2:0] enemy_size;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;
    bit mon_en = 1'b1;
    int exp_q[$];

    // bench-side record of what is currently on screen
    int m_px = 0, m_py = 0, m_ex = 0, m_ey = 0, m_es = 0;
    bit m_v = 1'b0;

    sprite_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .playerX    (playerX),
        .playerY    (playerY),
        .enemyX     (enemyX),
        .enemyY     (enemyY),
        .enemy_size (enemy_size),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pk(input int px, input int py, input int pc);
        return px * 1024 + py * 8 + pc;
    endfunction

    always @(negedge clk) begin
        if (mon_en && plot) begin
            if (exp_q.size() == 0) chk("pix_extra", pk(int'(x), int'(y), int'(colour)), -1);
            else chk("pix", pk(int'(x), int'(y), int'(colour)), exp_q.pop_front());
        end
    end

    task automatic push_sq(input int x0, input int y0, input int s, input int col);
        for (int r = 0; r < s; r++)
            for (int c = 0; c < s; c++)
                if (x0 + c < 160 && y0 + r < 120) exp_q.push_back(pk(x0 + c, y0 + r, col));
    endtask

    task automatic expect_redraw(input int px, input int py, input int ex, input int ey,
                                 input int es);
        if (m_v) push_sq(m_px, m_py, 4, 0);
        push_sq(px, py, 4, 2);
        if (m_v) push_sq(m_ex, m_ey, m_es, 0);
        push_sq(ex, ey, es, 4);
        m_px = px; m_py = py; m_ex = ex; m_ey = ey; m_es = es; m_v = 1'b1;
    endtask

    task automatic drive(input int px, input int py, input int ex, input int ey, input int es);
        playerX = px[7:0]; playerY = py[6:0];
        enemyX = ex[7:0]; enemyY = ey[6:0]; enemy_size = es[2:0];
    endtask

    task automatic redraw(input string tag, input int px, input int py, input int ex,
                          input int ey, input int es, input int ncyc, input int nplot);
        int np, first;
        bit got;
        expect_redraw(px, py, ex, ey, es);
        @(negedge clk);
        drive(px, py, ex, ey, es);
        start = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b0;
        np = 0; first = -1; got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (plot) begin
                np++;
                if (first < 0) first = cyc - c0 + 1;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk({tag, "_done_timeout"}, 0, 1);
        else chk({tag, "_done_cycle"}, cyc - c0 + 1, ncyc);
        chk({tag, "_first_pixel_cycle"}, first, 2);
        chk({tag, "_plots"}, np, nplot);
        @(negedge clk);
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int d1, d2, drop, extra;
        reset = 1'b1; start = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        redraw("first", 80, 100, 10, 20, 3, 26, 25);
        redraw("move", 81, 100, 12, 22, 3, 51, 50);
        redraw("corner", 158, 118, 50, 50, 2, 46, 33);
        redraw("no_enemy", 20, 30, 0, 0, 0, 37, 24);
        redraw("no_enemy2", 20, 31, 0, 0, 0, 33, 32);

        // start held and re-pulsed during a redraw: exactly one merged extra redraw
        expect_redraw(40, 40, 60, 60, 1);
        expect_redraw(41, 41, 61, 61, 1);
        @(negedge clk);
        drive(40, 40, 60, 60, 1);
        start = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b0;
        repeat (3) @(negedge clk);
        drive(41, 41, 61, 61, 1);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d1 = -1; d2 = -1; drop = 0;
        for (int i = 0; i < 300 && d2 < 0; i++) begin
            @(negedge clk);
            if (!busy) drop = 1;
            if (done) begin
                if (d1 < 0) d1 = cyc - c0 + 1;
                else d2 = cyc - c0 + 1;
            end
        end
        chk("pend_done1_cycle", d1, 34);
        chk("pend_done2_cycle", d2, 69);
        chk("pend_busy_drop", drop, 0);
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("pend_no_third", extra, 0);
        chk("pend_queue_left", exp_q.size(), 0);

        // reset during the 5th DRAW_P pixel (state cycle 21)
        mon_en = 1'b0;
        @(negedge clk);
        drive(100, 50, 0, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b0;
        repeat (21) @(negedge clk);
        chk("mid_busy_before", int'(busy), 1);
        chk("mid_plot_before", int'(plot), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_plot_after", int'(plot), 0);
        chk("mid_busy_after", int'(busy), 0);
        chk("mid_x_after", int'(x), 0);
        chk("mid_colour_after", int'(colour), 0);
        reset = 1'b0;
        m_v = 1'b0; m_px = 0; m_py = 0; m_ex = 0; m_ey = 0; m_es = 0;
        exp_q.delete();
        @(posedge clk); #1;
        mon_en = 1'b1;
        redraw("after_reset", 5, 5, 7, 7, 2, 21, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
